// File: rtl/seg_accum_pkg.sv
// Shared FSM encoding and segment geometry for the segmented accumulator.
package seg_accum_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  function automatic int seg_count(input int w, input int n);
    return w / n;
  endfunction

  function automatic bit seg_cfg_ok(input int w, input int n);
    return (n >= 1) && (w >= n) && ((w % n) == 0);
  endfunction

endpackage

// File: rtl/seg_accum_ctrl_adder.sv
// seg_carry_adder: S segments of N bits, each carry-in registered from
// the segment below; carries settle one hop per clock.
module seg_carry_adder
  import seg_accum_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_carry,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int S = seg_count(W, N);

  logic [W-1:0] seg_sum;
  logic [S-1:0] seg_co;
  logic [W-1:0] sum_d, sum_q;
  logic [S-1:0] carry_d, carry_q;

  for (genvar k = 0; k < S; k++) begin : g_seg
    logic ci;
    if (k == 0) begin : g_lsb
      assign ci = 1'b0;
    end else begin : g_up
      assign ci = carry_q[k-1];
    end
    assign {seg_co[k], seg_sum[k*N +: N]} =
      {1'b0, a[k*N +: N]} + {1'b0, b[k*N +: N]} +
      {{N{1'b0}}, ci};
  end

  always_comb begin
    sum_d   = seg_sum;
    carry_d = clr_carry ? '0 : seg_co;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  // top segment's carry register doubles as the registered carry-out
  assign sum  = sum_q;
  assign cout = carry_q[S-1];

endmodule

// File: rtl/seg_accum_ctrl.sv
// seg_accum_ctrl: handshake-fed accumulator around seg_carry_adder.
// Build option SEG_ACCUM_SATURATE_EN: clamp to all-ones on carry-out.
module seg_accum_ctrl
  import seg_accum_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] acc,
  output logic         acc_valid,
  output logic         overflow,
  output logic         busy
);

  localparam int S  = seg_count(W, N);
  localparam int CW = (S > 1) ? $clog2(S) : 1;
  localparam logic [CW-1:0] LAST = CW'(S - 1);

  if (!seg_cfg_ok(W, N)) begin : g_bad_cfg
    $error("seg_accum_ctrl: W must be a positive multiple of N");
  end

  state_t         state_d, state_q;
  logic [CW-1:0]  cnt_d, cnt_q;
  logic [W-1:0]   opa_d, opa_q;
  logic [W-1:0]   acc_d, acc_q;
  logic           vld_d, vld_q;
  logic           ovf_d, ovf_q;
  logic [W-1:0]   sum;
  logic           cout;
  logic [W-1:0]   commit_val;
  logic           accept;

  assign in_ready = (state_q == IDLE) && !clr;
  assign accept   = in_valid && in_ready;

  seg_carry_adder #(.W(W), .N(N)) u_adder (
    .clk       (clk),
    .rst       (rst),
    .clr_carry (accept || clr),
    .a         (opa_q),
    .b         (acc_q),
    .sum       (sum),
    .cout      (cout)
  );

`ifdef SEG_ACCUM_SATURATE_EN
  assign commit_val = cout ? '1 : sum;
`else
  assign commit_val = sum;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    vld_d   = 1'b0;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = SETTLE;
            opa_d   = in_data;
            cnt_d   = '0;
          end
        end
        SETTLE: begin
          if (cnt_q == LAST) state_d = COMMIT;
          else cnt_d = cnt_q + CW'(1);
        end
        COMMIT: begin
          acc_d   = commit_val;
          ovf_d   = ovf_q | cout;
          vld_d   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      acc_q   <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      acc_q   <= acc_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc       = acc_q;
  assign acc_valid = vld_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seg_accum_ctrl.sv
// Scoreboard bench for seg_accum_ctrl at N=4, N=1 and N=16 (W=16).
module tb_seg_accum_ctrl;

  typedef struct {
    int          idx;
    logic [15:0] acc;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [2:0]  v;
  logic [2:0]  rdy;
  logic [2:0]  av;
  logic [2:0]  ov;
  logic [2:0]  bz;
  logic [15:0] d [3];
  logic [15:0] a [3];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sbq[$];

`ifdef SEG_ACCUM_SATURATE_EN
  localparam logic [15:0] E_FF2  = 16'hFFFF;
  localparam logic [15:0] E_FF21 = 16'hFFFF;
  localparam logic [15:0] E_N16  = 16'hFFFF;
`else
  localparam logic [15:0] E_FF2  = 16'h0001;
  localparam logic [15:0] E_FF21 = 16'h0002;
  localparam logic [15:0] E_N16  = 16'h0000;
`endif

  seg_accum_ctrl #(.W(16), .N(4)) u_n4 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(v[0]), .in_ready(rdy[0]), .in_data(d[0]),
    .acc(a[0]), .acc_valid(av[0]),
    .overflow(ov[0]), .busy(bz[0])
  );

  seg_accum_ctrl #(.W(16), .N(1)) u_n1 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(v[1]), .in_ready(rdy[1]), .in_data(d[1]),
    .acc(a[1]), .acc_valid(av[1]),
    .overflow(ov[1]), .busy(bz[1])
  );

  seg_accum_ctrl #(.W(16), .N(16)) u_n16 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(v[2]), .in_ready(rdy[2]), .in_data(d[2]),
    .acc(a[2]), .acc_valid(av[2]),
    .overflow(ov[2]), .busy(bz[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int i);
    return (i == 0) ? 5 : (i == 1) ? 17 : 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard monitor: every acc_valid pulse must match a queued entry
  always @(negedge clk) begin
    int k;
    for (int i = 0; i < 3; i++) begin
      if (av[i]) begin
        k = -1;
        for (int j = 0; j < sbq.size(); j++)
          if (k < 0 && sbq[j].idx == i) k = j;
        if (k < 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid inst%0d: acc=%0h", i, a[i]);
        end else begin
          chk($sformatf("acc%0d", i), 32'(a[i]), 32'(sbq[k].acc));
          chk($sformatf("ovf%0d", i), 32'(ov[i]), 32'(sbq[k].ovf));
          chk($sformatf("lat%0d", i), cyc, sbq[k].cyc);
          sbq.delete(k);
        end
      end
    end
  end

  task automatic accept(input int i, input logic [15:0] dat,
                        output int acyc);
    int n;
    n = 0;
    @(negedge clk);
    v[i] = 1'b1;
    d[i] = dat;
    while (!rdy[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[i]) chk($sformatf("ready_wait%0d", i), 32'(rdy[i]), 1);
    acyc = cyc + 1;
    @(posedge clk);
    #1;
    v[i] = 1'b0;
    d[i] = 16'($urandom);
  endtask

  task automatic send(input int i, input logic [15:0] dat,
                      input logic [15:0] ea, input logic eo);
    exp_t e;
    int   acyc;
    int   n;
    accept(i, dat, acyc);
    e.idx = i;
    e.acc = ea;
    e.ovf = eo;
    e.cyc = acyc + lat_of(i);
    sbq.push_back(e);
    n = 0;
    @(negedge clk);
    while (!rdy[i] && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("ready_low%0d", i), n, lat_of(i));
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    int acyc;
    int n;
    rst = 1'b0;
    clr = 1'b0;
    v   = '0;
    for (int i = 0; i < 3; i++) d[i] = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_acc", 32'(a[0]), 0);
    chk("rst_valid", 32'(av[0]), 0);
    chk("rst_ovf", 32'(ov[0]), 0);
    chk("rst_busy", 32'(bz[0]), 0);
    #19 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(rdy), 32'h7);

    send(0, 16'd32, 16'd32, 1'b0);
    send(0, 16'd32, 16'd64, 1'b0);
    send(0, 16'd32, 16'd96, 1'b0);

    do_clr();
    send(0, 16'h0FFF, 16'h0FFF, 1'b0);
    send(0, 16'h0001, 16'h1000, 1'b0);

    do_clr();
    send(0, 16'hFFFF, 16'hFFFF, 1'b0);
    send(0, 16'h0002, E_FF2, 1'b1);
    send(0, 16'h0001, E_FF21, 1'b1);

    do_clr();
    @(negedge clk);
    chk("clr_acc", 32'(a[0]), 0);
    chk("clr_ovf", 32'(ov[0]), 0);

    accept(0, 16'h1234, acyc);
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("abort_acc", 32'(a[0]), 0);
    chk("abort_busy", 32'(bz[0]), 0);
    chk("abort_ready", 32'(rdy[0]), 1);
    repeat (8) @(negedge clk);

    send(0, 16'h0007, 16'h0007, 1'b0);
    @(negedge clk);
    clr  = 1'b1;
    v[0] = 1'b1;
    d[0] = 16'h0009;
    #1;
    chk("clr_ready_low", 32'(rdy[0]), 0);
    @(posedge clk);
    #1;
    clr  = 1'b0;
    v[0] = 1'b0;
    @(negedge clk);
    chk("drop_acc", 32'(a[0]), 0);
    chk("drop_busy", 32'(bz[0]), 0);
    repeat (8) @(negedge clk);

    send(0, 16'hFFFF, 16'hFFFF, 1'b0);
    send(0, 16'h0002, E_FF2, 1'b1);
    accept(0, 16'h0100, acyc);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_acc", 32'(a[0]), 0);
    chk("arst_busy", 32'(bz[0]), 0);
    chk("arst_ovf", 32'(ov[0]), 0);
    chk("arst_valid", 32'(av[0]), 0);
    #8 rst = 1'b0;
    send(0, 16'h0005, 16'h0005, 1'b0);

    send(1, 16'h7FFF, 16'h7FFF, 1'b0);
    send(1, 16'h0001, 16'h8000, 1'b0);
    send(2, 16'h00FF, 16'h00FF, 1'b0);
    send(2, 16'hFF01, E_N16, 1'b1);

    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sbq.size(), 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_accum_ctrl.md
Name: seg_accum_ctrl

Overview:
- Sequencing accumulator that owns the segmented carry-pipelined adder and the commit logic around it.
- Accepts addends over a valid/ready handshake and applies them to its accumulator.
- Clears the carry pipeline on every load, waits the fixed settle window, then commits and pulses a result strobe.
- Replaces ad-hoc free-running settle counters. Sits directly downstream of the adder's registered sum and feeds the accumulator value back as its second operand.

Parameters:
- W, 16, total accumulator width.
- N, 4, segment width; W % N == 0 required, N >= 1; S = W/N segments.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- clr  in  1  synchronous clear of accumulator, overflow flag and any in-flight add.
- in_valid  in  1  addend present.
- in_ready  out  1  block can accept an addend this cycle.
- in_data  in  W  addend.
- acc  out  W  committed accumulator value.
- acc_valid  out  1  one-cycle pulse: acc updated this cycle.
- overflow  out  1  sticky: a commit produced carry-out of the top segment.
- busy  out  1  add in flight (state != IDLE).

Behaviour:
- Reset (async, rst=1): state IDLE, acc=0, acc_valid=0, overflow=0, operand/carry/sum registers 0. in_ready=1 once rst deasserts (state IDLE, clr low).
- in_ready = (state==IDLE) && !clr, combinational. Accept = in_valid && in_ready at edge E0.
- FSM, IDLE -> SETTLE:
  - at E0, latch in_data into operand register (held stable until commit).
  - clear all S-1 inter-segment carry registers and the settle counter.
- FSM, SETTLE:
  - counter increments each edge; adder sum and carry registers update each edge.
  - after E_S, carries have propagated through all S-1 hops and the sum register is exact.
  - at the edge where counter == S-1 (i.e. E_S), go to COMMIT.
- FSM, COMMIT -> IDLE:
  - at E_{S+1}, acc <= sum.
  - overflow |= top-segment carry-out (registered alongside sum at E_S).
  - go to IDLE.
  - acc_valid is high for exactly the cycle following E_{S+1}.
- Latency: accept at E0 -> acc updated at E_{S+1}. Accept-to-accept period is S+2 cycles (W=16, N=4: 5 edges latency, 6-cycle period).
- Operand b is always the registered acc. It does not change while busy.
- Arithmetic is modulo 2^W: wraps on overflow. The overflow flag never self-clears; only clr or rst clear it.
- clr in IDLE: acc=0, overflow=0 next edge, any coincident in_valid dropped (in_ready is low).
- clr in SETTLE/COMMIT: add aborted, state IDLE, acc=0, no acc_valid pulse. clr wins over a coincident commit.
- rst mid-operation: immediate return to reset values; no pulse.
- N == W (S=1): SETTLE lasts one edge; latency 2.
- in_data changes while busy are ignored.

Optional Feature:
- Macro: SEG_ACCUM_SATURATE_EN.
- Defined: on a commit with top carry-out, acc <= all-ones instead of the wrapped sum; overflow is still set.
- Undefined: wrap modulo 2^W as above.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, SETTLE, COMMIT).
  - localparam function for S = W/N.
  - elaboration check for W % N.
- One sub-module, seg_carry_adder (W, N):
  - S adder segments of width N, each carry-in registered from the previous segment's carry-out.
  - registered W-bit sum, registered top carry-out.
  - synchronous carry-clear input driven by the controller on load.
- Controller FSM, counter and accumulator live in seg_accum_ctrl.

Test Plan:
- W=16, N=4: reset, three accepts of 32 -> acc 32, 64, 96; each acc_valid pulse 5 edges after its accept; in_ready low for 5 cycles each.
- acc=0x0FFF, add 0x0001 -> acc=0x1000 (carry ripples through 3 segments), overflow=0. Checks the settle window is not short.
- acc=0xFFFF, add 0x0002 -> acc=0x0001, overflow=1 and stays 1 after a further add of 1 (acc=0x0002). With SEG_ACCUM_SATURATE_EN: acc=0xFFFF, overflow=1.
- Accept 0x1234 then clr on 2nd SETTLE cycle -> no acc_valid, acc=0x0000, in_ready=1 the following cycle. Concurrent in_valid+clr in IDLE -> addend dropped.
- rst pulsed (not clock-aligned) during SETTLE -> acc=0, busy=0, overflow=0 immediately; next add of 5 -> acc=5.
- W=16, N=1: acc=0x7FFF, add 0x0001 -> acc=0x8000 after 17 edges, overflow=0. W=16, N=16: latency 2 edges.
